// File: rtl/dmem_port_arbiter.sv
// Shares the processor-to-memory bus between a committed-store queue, load reads
// and fetch reads. It also tracks outstanding read tags so returned data reaches its owner.
module dmem_port_arbiter #(
  parameter int unsigned SQ_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MEM_SIZE_W   = 2
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  st_valid,
  input  logic [XLEN-1:0]       st_addr,
  input  logic [XLEN-1:0]       st_data,
  input  logic [MEM_SIZE_W-1:0] st_size,
  output logic                  st_ready,

  input  logic                  ld_req,
  input  logic [XLEN-1:0]       ld_addr,
  input  logic [MEM_SIZE_W-1:0] ld_size,
  output logic                  ld_grant,
  output logic                  ld_data_valid,
  output logic [63:0]           ld_data,
  input  logic                  ld_squash,

  input  logic                  if_req,
  input  logic [XLEN-1:0]       if_addr,
  output logic                  if_grant,
  output logic                  if_data_valid,
  output logic [63:0]           if_data,

  output logic                  sq_empty,

  output logic [1:0]            proc2mem_command,
  output logic [XLEN-1:0]       proc2mem_addr,
  output logic [63:0]           proc2mem_data,
  output logic [MEM_SIZE_W-1:0] proc2mem_size,
  input  logic [3:0]            mem2proc_response,
  input  logic [63:0]           mem2proc_data,
  input  logic [3:0]            mem2proc_tag
);

  localparam int unsigned PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  // Fetch always reads a full doubleword.
  localparam logic [MEM_SIZE_W-1:0] FETCH_SIZE = '1;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LOAD,
    OWN_FETCH,
    OWN_DROPPED
  } owner_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_STORE,
    SEL_LOAD,
    SEL_FETCH
  } sel_t;

  logic [XLEN-1:0]       sq_addr [SQ_DEPTH];
  logic [XLEN-1:0]       sq_data [SQ_DEPTH];
  logic [MEM_SIZE_W-1:0] sq_size [SQ_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve;

  owner_t owner      [16];
  owner_t owner_next [16];
  owner_t ret_owner;

  logic     full;
  logic     nonempty;
  logic     starved;
  logic     hazard;
  logic     accepted;
  logic     push;
  logic     pop;
  sel_t     sel;
  bus_cmd_t cmd;

  assign full     = (count == CNT_W'(SQ_DEPTH));
  assign nonempty = (count != '0);
  assign starved  = (starve >= STV_W'(STARVE_LIMIT));
  assign accepted = (mem2proc_response != 4'h0);

  assign st_ready = reset && (count < CNT_W'(SQ_DEPTH));
  assign sq_empty = !reset || !nonempty;
  assign push     = st_valid && st_ready;

  // A load may not pass any queued store to the same doubleword.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if ({1'b0, PTR_W'(i) - head} < count &&
          sq_addr[PTR_W'(i)][XLEN-1:3] == ld_addr[XLEN-1:3]) begin
        hazard = 1'b1;
      end
    end
  end

  // A hazarded load hands its priority slot to the store head, which is what clears the hazard.
  always_comb begin
    sel = SEL_NONE;
    if (reset) begin
      if (nonempty && (full || starved)) begin
        sel = SEL_STORE;
      end else if (ld_req) begin
        sel = hazard ? SEL_STORE : SEL_LOAD;
      end else if (if_req) begin
        sel = SEL_FETCH;
      end else if (nonempty) begin
        sel = SEL_STORE;
      end
    end
  end

  always_comb begin
    cmd           = BUS_NONE;
    proc2mem_addr = '0;
    proc2mem_data = '0;
    proc2mem_size = '0;
    unique case (sel)
      SEL_STORE: begin
        cmd                      = BUS_STORE;
        proc2mem_addr            = sq_addr[head];
        proc2mem_data[XLEN-1:0]  = sq_data[head];
        proc2mem_size            = sq_size[head];
      end
      SEL_LOAD: begin
        cmd           = BUS_LOAD;
        proc2mem_addr = ld_addr;
        proc2mem_size = ld_size;
      end
      SEL_FETCH: begin
        cmd           = BUS_LOAD;
        proc2mem_addr = if_addr;
        proc2mem_size = FETCH_SIZE;
      end
      default: ;
    endcase
  end

  assign proc2mem_command = cmd;
  assign ld_grant         = (sel == SEL_LOAD)  && accepted;
  assign if_grant         = (sel == SEL_FETCH) && accepted;
  assign pop              = (sel == SEL_STORE) && accepted;

  assign ret_owner     = owner[mem2proc_tag];
  assign ld_data_valid = reset && (mem2proc_tag != 4'h0) && (ret_owner == OWN_LOAD);
  assign if_data_valid = reset && (mem2proc_tag != 4'h0) && (ret_owner == OWN_FETCH);
  assign ld_data       = ld_data_valid ? mem2proc_data : '0;
  assign if_data       = if_data_valid ? mem2proc_data : '0;

  // Return clears first, squash then drops live loads, and a fresh grant overrides both.
  always_comb begin
    for (int unsigned t = 0; t < 16; t++) begin
      owner_next[t] = owner[t];
      if (mem2proc_tag != 4'h0 && mem2proc_tag == 4'(t)) begin
        owner_next[t] = OWN_NONE;
      end
      if (ld_squash && owner_next[t] == OWN_LOAD) begin
        owner_next[t] = OWN_DROPPED;
      end
      if (ld_grant && mem2proc_response == 4'(t)) begin
        owner_next[t] = ld_squash ? OWN_DROPPED : OWN_LOAD;
      end
      if (if_grant && mem2proc_response == 4'(t)) begin
        owner_next[t] = OWN_FETCH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      sq_addr[tail] <= st_addr;
      sq_data[tail] <= st_data;
      sq_size[tail] <= st_size;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      starve <= '0;
      for (int unsigned t = 0; t < 16; t++) begin
        owner[t] <= OWN_NONE;
      end
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (!nonempty || pop) begin
        starve <= '0;
      end else if (!starved) begin
        starve <= starve + STV_W'(1);
      end
      for (int unsigned t = 0; t < 16; t++) begin
        owner[t] <= owner_next[t];
      end
    end
  end

endmodule
